dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single synchronous data RAM of the RV32IM core between two requesters.
  - Port 0 is the CPU data port.
  - Port 1 is a secondary master, such as a program/data loader or a DMA engine.
- Port 0 has fixed priority; a starvation counter guarantees port 1 forward progress.
- Port 1 can lock the RAM for an atomic burst.
- Sits between the core/peripheral masters and the RAM instance inside top.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_W_RAM, 13, RAM word-address width
MAX_WAIT, 4, consecutive cycles port 1 may wait (req high, no gnt) before it is force-granted; range 1..15

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
m0_req  input  1  port 0 access request, held until m0_gnt
m0_we  input  1  port 0 write enable (1 write, 0 read)
m0_addr  input  ADDR_W_RAM  port 0 word address
m0_wdata  input  DATA_WIDTH  port 0 write data
m0_be  input  DATA_WIDTH/8  port 0 byte enables
m0_gnt  output  1  port 0 access accepted this cycle
m0_rvalid  output  1  port 0 read data valid
m0_rdata  output  DATA_WIDTH  port 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_be  input  as port 0  port 1 request fields
m1_lock  input  1  port 1 requests exclusive ownership while high
m1_gnt, m1_rvalid, m1_rdata  output  as port 0  port 1 responses
ram_en  output  1  RAM access strobe
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W_RAM  RAM address
ram_wdata  output  DATA_WIDTH  RAM write data
ram_be  output  DATA_WIDTH/8  RAM byte enables
ram_rdata  input  DATA_WIDTH  RAM read data, valid 1 cycle after a read strobe
owner  output  1  port granted in the current cycle (0/1); holds the last value when idle
starve_cnt  output  4  current port 1 wait count (debug)

Behaviour:
- Reset (reset=0, asynchronous): state=ARB, owner=0, starve_cnt=0, rd_pending=0, rd_owner=0. All gnt/rvalid low; rdata outputs 0.
- Grants are combinational from registered state and current req.
  - Exactly one access per cycle.
  - ram_en equals m0_gnt|m1_gnt; ram_* fields are muxed from the granted port.
  - When no port is granted, ram_en=0, ram_we=0 and ram_be=0.
- Request rule: a requester holds req and all fields stable until gnt. One gnt completes one access; a requester with req still high after gnt is a new request.
- States:
  - ARB:
    - m0_req=1 and starve_cnt<MAX_WAIT: grant m0.
    - Otherwise, if m1_req=1: grant m1.
    - m1_req=1 and not granted: starve_cnt increments, saturating at MAX_WAIT. starve_cnt clears on any m1 grant or when m1_req=0.
    - A granted m1 access with m1_lock=1 moves to LOCK.
  - LOCK:
    - Only m1 can be granted; m0 gnt is forced 0.
    - Return to ARB at the first clock edge where m1_lock=0 or m1_req=0. The m1 access granted in that same cycle still completes.
    - starve_cnt is held at 0 in LOCK.
- Starvation boundary: when starve_cnt==MAX_WAIT and both ports request, m1 is granted for exactly that one cycle.
- Read path:
  - A granted read (we=0) sets rd_pending=1 and rd_owner=granted port at the clock edge.
  - Next cycle: the owner's rvalid=1 and its rdata=ram_rdata, captured into a hold register. The non-owner's rvalid=0 and its rdata holds its last value.
  - Throughput is one read per cycle; back-to-back reads from alternating ports are supported.
- Writes produce no rvalid.
- Lock requested while m0 is being granted: lock takes effect only when m1 is next granted.
- Reset mid-burst: all state clears immediately; outstanding rvalid is dropped.
- Throughout, m0_gnt&m1_gnt is never 1.

Test Plan:
- Reset held low 3 cycles, release → all gnt/rvalid=0, owner=0, starve_cnt=0; ram_en=0 while idle.
- m0 alone writes addr 25, data 25, be=4'hF; then reads addr 25 → ram_we=1 in the grant cycle; m0_rvalid=1 with m0_rdata=25 exactly one cycle after the read grant.
- m0_req held high continuously, m1_req high from cycle 0, MAX_WAIT=4 → m0 granted cycles 0-3; m1 granted in cycle 4; starve_cnt sequence 1,2,3,4,0.
- m1 locked burst: m1_lock=1, 4 writes to addrs 96..99 with m0_req high throughout → m1_gnt for 4 consecutive cycles, m0_gnt=0. After m1_lock drops, m0 is granted the next cycle.
- Alternating reads: m0 reads addr 10 and m1 reads addr 11 in consecutive cycles (RAM preloaded 0xA, 0xB) → m0_rvalid then m1_rvalid on consecutive cycles, with rdata 0xA and 0xB; neither port sees the other's rvalid.
- Reset asserted mid-LOCK burst → state returns to ARB asynchronously, pending rvalid suppressed; first access after release is granted normally.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-cycle data RAM: fixed priority to port 0, starvation-bounded port 1, port 1 lockable bursts.
// Grants are combinational (zero latency); read data returns one cycle after the grant; a requester holds its fields until granted.
module dmem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W_RAM = 13,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_req,
  input  logic                    m0_we,
  input  logic [ADDR_W_RAM-1:0]   m0_addr,
  input  logic [DATA_WIDTH-1:0]   m0_wdata,
  input  logic [DATA_WIDTH/8-1:0] m0_be,
  output logic                    m0_gnt,
  output logic                    m0_rvalid,
  output logic [DATA_WIDTH-1:0]   m0_rdata,
  input  logic                    m1_req,
  input  logic                    m1_we,
  input  logic [ADDR_W_RAM-1:0]   m1_addr,
  input  logic [DATA_WIDTH-1:0]   m1_wdata,
  input  logic [DATA_WIDTH/8-1:0] m1_be,
  input  logic                    m1_lock,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_WIDTH-1:0]   m1_rdata,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [ADDR_W_RAM-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    owner,
  output logic [3:0]              starve_cnt
);

  localparam logic [0:0] StArb   = 1'b0;
  localparam logic [0:0] StLock  = 1'b1;
  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  logic [0:0]            state;
  logic [0:0]            nextState;
  logic [3:0]            starveCnt;
  logic [3:0]            starveNext;
  logic                  ownerReg;
  logic                  rdPending;
  logic                  rdOwner;
  logic [DATA_WIDTH-1:0] m0Hold;
  logic [DATA_WIDTH-1:0] m1Hold;

  // Grants are suppressed while reset is asserted so nothing reaches the RAM.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (reset) begin
      if (state == StArb && m0_req && starveCnt < MaxWait) begin
        m0_gnt = 1'b1;
      end else begin
        m1_gnt = m1_req;
      end
    end
  end

  always_comb begin
    ram_en    = m0_gnt | m1_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_be    = '0;
    if (m1_gnt) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_be    = m1_be;
    end else if (m0_gnt) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_be    = m0_be;
    end
  end

  always_comb begin
    starveNext = '0;
    if (state == StArb && m1_req && !m1_gnt) begin
      starveNext = (starveCnt >= MaxWait) ? MaxWait : starveCnt + 4'd1;
    end
  end

  // The access granted in the cycle the lock drops still completes normally.
  always_comb begin
    nextState = state;
    if (state == StArb) begin
      if (m1_gnt && m1_lock) nextState = StLock;
    end else if (!m1_lock || !m1_req) begin
      nextState = StArb;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StArb;
      starveCnt <= '0;
      ownerReg  <= 1'b0;
      rdPending <= 1'b0;
      rdOwner   <= 1'b0;
      m0Hold    <= '0;
      m1Hold    <= '0;
    end else begin
      state     <= nextState;
      starveCnt <= starveNext;
      rdPending <= ram_en & ~ram_we;
      if (ram_en) ownerReg <= m1_gnt;
      if (ram_en && !ram_we) rdOwner <= m1_gnt;
      if (m0_rvalid) m0Hold <= ram_rdata;
      if (m1_rvalid) m1Hold <= ram_rdata;
    end
  end

  assign m0_rvalid  = rdPending & ~rdOwner;
  assign m1_rvalid  = rdPending & rdOwner;
  assign m0_rdata   = m0_rvalid ? ram_rdata : m0Hold;
  assign m1_rdata   = m1_rvalid ? ram_rdata : m1Hold;
  assign owner      = m1_gnt | (~m0_gnt & ownerReg);
  assign starve_cnt = starveCnt;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: behavioural RAM, reference model with per-cycle compare, directed scenarios then random traffic.
module tb_dmem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 13;
  localparam int BW = DW / 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic [BW-1:0] m0_be, m1_be;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_rdata;
  logic          owner;
  logic [3:0]    starve_cnt;

  int checks = 0;
  int errors = 0;

  dmem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_W_RAM(AW), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_be(ram_be), .ram_rdata(ram_rdata), .owner(owner), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural RAM driven by the DUT's RAM port.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int j = 0; j < BW; j++) if (ram_be[j]) ram[ram_addr][8*j +: 8] = ram_wdata[8*j +: 8];
      end else begin
        ram_rdata <= ram[ram_addr];
      end
    end
  end

  // Reference model: shadow memory plus arbitration bookkeeping.
  logic [DW-1:0] refMem [0:(1<<AW)-1];
  bit            mLocked = 0;
  int            mWait = 0;
  bit            mPend = 0;
  bit            mPendPort = 0;
  logic [DW-1:0] mPendData = '0;
  bit            mOwner = 0;
  logic [DW-1:0] mHold0 = '0;
  logic [DW-1:0] mHold1 = '0;
  bit            lastG0 = 0;
  bit            lastG1 = 0;
  logic          mg0, mg1, cg0, cg1;
  logic          uWe;
  logic [AW-1:0] uAddr;
  logic [DW-1:0] uData;
  logic [BW-1:0] uBe;

  function automatic void modelGrant(output logic g0, output logic g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) begin
      if (!mLocked && m0_req && mWait < MW) g0 = 1'b1;
      else g1 = m1_req;
    end
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mLocked = 0; mWait = 0; mPend = 0; mPendPort = 0; mOwner = 0;
      mHold0 = '0; mHold1 = '0; lastG0 = 0; lastG1 = 0;
    end else begin
      modelGrant(mg0, mg1);
      if (mPend) begin
        if (mPendPort) mHold1 = mPendData;
        else mHold0 = mPendData;
      end
      mPend = 0;
      if (mg0 || mg1) begin
        uWe   = mg1 ? m1_we    : m0_we;
        uAddr = mg1 ? m1_addr  : m0_addr;
        uData = mg1 ? m1_wdata : m0_wdata;
        uBe   = mg1 ? m1_be    : m0_be;
        if (uWe) begin
          for (int j = 0; j < BW; j++) if (uBe[j]) refMem[uAddr][8*j +: 8] = uData[8*j +: 8];
        end else begin
          mPend = 1; mPendPort = mg1; mPendData = refMem[uAddr];
        end
        mOwner = mg1;
      end
      if (mLocked) mWait = 0;
      else if (m1_req && !mg1) mWait = (mWait + 1 > MW) ? MW : mWait + 1;
      else mWait = 0;
      mLocked = mLocked ? (m1_lock && m1_req) : (mg1 && m1_lock);
      lastG0 = mg0;
      lastG1 = mg1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    modelGrant(cg0, cg1);
    chk("m0_gnt", m0_gnt, cg0);
    chk("m1_gnt", m1_gnt, cg1);
    chk("m0_rvalid", m0_rvalid, mPend && !mPendPort);
    chk("m1_rvalid", m1_rvalid, mPend && mPendPort);
    chk("m0_rdata", m0_rdata, (mPend && !mPendPort) ? mPendData : mHold0);
    chk("m1_rdata", m1_rdata, (mPend && mPendPort) ? mPendData : mHold1);
    chk("owner", owner, cg1 ? 1 : (cg0 ? 0 : mOwner));
    chk("starve_cnt", starve_cnt, mWait);
    chk("ram_en", ram_en, cg0 | cg1);
    if (cg1) begin
      chk("ram_we", ram_we, m1_we); chk("ram_addr", ram_addr, m1_addr);
      chk("ram_wdata", ram_wdata, m1_wdata); chk("ram_be", ram_be, m1_be);
    end else if (cg0) begin
      chk("ram_we", ram_we, m0_we); chk("ram_addr", ram_addr, m0_addr);
      chk("ram_wdata", ram_wdata, m0_wdata); chk("ram_be", ram_be, m0_be);
    end else begin
      chk("ram_we_idle", ram_we, 0); chk("ram_be_idle", ram_be, 0);
    end
  end

  task automatic newReq0();
    m0_req   = ($urandom_range(0, 9) < 7);
    m0_we    = 1'($urandom_range(0, 1));
    m0_addr  = AW'($urandom_range(0, 15));
    m0_wdata = $urandom;
    m0_be    = BW'($urandom_range(0, 15));
  endtask

  task automatic newReq1();
    m1_req   = ($urandom_range(0, 9) < 5);
    m1_we    = 1'($urandom_range(0, 1));
    m1_addr  = AW'($urandom_range(0, 15));
    m1_wdata = $urandom;
    m1_be    = BW'($urandom_range(0, 15));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = DW'(i);
      refMem[i] = DW'(i);
    end
    ram_rdata = '0;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = '0; m1_lock = 0;

    // Reset for 3 cycles, then idle outputs.
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("rst_m0_gnt", m0_gnt, 0); chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0); chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_owner", owner, 0); chk("rst_starve", starve_cnt, 0);
    chk("rst_ram_en", ram_en, 0); chk("rst_m0_rdata", m0_rdata, 0);

    // Port 0 write then read of address 25.
    nextCycle();
    m0_req = 1; m0_we = 1; m0_addr = 25; m0_wdata = 25; m0_be = 4'hF;
    @(negedge clk);
    chk("wr_gnt", m0_gnt, 1); chk("wr_ram_we", ram_we, 1); chk("wr_ram_addr", ram_addr, 25);
    nextCycle();
    m0_we = 0;
    @(negedge clk);
    chk("rd_gnt", m0_gnt, 1); chk("rd_ram_we", ram_we, 0);
    nextCycle();
    m0_req = 0;
    @(negedge clk);
    chk("rd_rvalid", m0_rvalid, 1); chk("rd_rdata", m0_rdata, 25); chk("rd_m1_rvalid", m1_rvalid, 0);

    // Starvation: both ports request continuously.
    nextCycle();
    m0_req = 1; m0_we = 1; m0_addr = 200; m0_wdata = 32'hC0DE; m0_be = 4'hF;
    m1_req = 1; m1_we = 1; m1_addr = 201; m1_wdata = 32'hBEEF; m1_be = 4'hF; m1_lock = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("starve_m0_gnt", m0_gnt, (k < 4) ? 1 : 0);
      chk("starve_m1_gnt", m1_gnt, (k == 4) ? 1 : 0);
      nextCycle();
      chk("starve_seq", starve_cnt, (k < 4) ? k + 1 : 0);
    end
    m0_req = 0; m1_req = 0;

    // Locked port 1 burst to 96..99 with port 0 requesting.
    m1_req = 1; m1_lock = 1; m1_we = 1; m1_addr = 96; m1_wdata = 32'h60; m1_be = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lock_m1_gnt", m1_gnt, 1); chk("lock_m0_gnt", m0_gnt, 0); chk("lock_addr", ram_addr, 96 + i);
      nextCycle();
      m0_req = 1; m0_we = 1; m0_addr = 300; m0_wdata = 32'h300; m0_be = 4'hF;
      if (i < 3) begin
        m1_addr = AW'(97 + i); m1_wdata = DW'(32'h61 + i);
      end else begin
        m1_req = 0; m1_lock = 0;
      end
    end
    @(negedge clk);
    chk("lock_exit_m0", m0_gnt, 0); chk("lock_exit_m1", m1_gnt, 0);
    nextCycle();
    @(negedge clk);
    chk("after_lock_m0", m0_gnt, 1);

    // Alternating reads of preloaded addresses 10 and 11.
    nextCycle();
    m0_we = 0; m0_addr = 10;
    @(negedge clk);
    chk("alt_m0_gnt", m0_gnt, 1);
    nextCycle();
    m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 11;
    @(negedge clk);
    chk("alt_m0_rvalid", m0_rvalid, 1); chk("alt_m0_rdata", m0_rdata, 32'hA);
    chk("alt_m1_rvalid0", m1_rvalid, 0); chk("alt_m1_gnt", m1_gnt, 1);
    nextCycle();
    m1_req = 0;
    @(negedge clk);
    chk("alt_m1_rvalid", m1_rvalid, 1); chk("alt_m1_rdata", m1_rdata, 32'hB);
    chk("alt_m0_rvalid0", m0_rvalid, 0);

    // Asynchronous reset in the middle of a locked read burst.
    nextCycle();
    m1_req = 1; m1_lock = 1; m1_we = 0; m1_addr = 12;
    @(negedge clk);
    chk("mid_m1_gnt", m1_gnt, 1);
    @(posedge clk);
    #3 reset = 0;
    #1;
    chk("mid_rst_rvalid", m1_rvalid, 0); chk("mid_rst_gnt", m1_gnt, 0);
    chk("mid_rst_ram_en", ram_en, 0); chk("mid_rst_starve", starve_cnt, 0);
    m1_req = 0; m1_lock = 0;
    nextCycle();
    reset = 1;
    m0_req = 1; m0_we = 0; m0_addr = 13;
    @(negedge clk);
    chk("post_rst_gnt", m0_gnt, 1); chk("post_rst_addr", ram_addr, 13);
    nextCycle();
    m0_req = 0;
    @(negedge clk);
    chk("post_rst_rvalid", m0_rvalid, 1); chk("post_rst_rdata", m0_rdata, 13);

    // Random traffic with one asynchronous reset pulse.
    for (int c = 0; c < 4000; c++) begin
      nextCycle();
      if (c == 2000) begin
        #2 reset = 0;
        nextCycle();
        reset = 1;
      end
      if (!m0_req || lastG0) newReq0();
      if (!m1_req || lastG1) newReq1();
      if ($urandom_range(0, 7) == 0) m1_lock = ~m1_lock;
    end
    nextCycle();
    m0_req = 0; m1_req = 0; m1_lock = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
